// File: rtl/cache_lookup_ctrl.sv
// Direct-mapped read-cache controller in front of a dual-port, async-read RAM.
// Entries are packed {valid, tag, data}; misses are fetched from backing memory and filled.
module cache_lookup_ctrl #(
  parameter int ADDR_WIDTH = 11,
  parameter int TAG_WIDTH  = 15,
  parameter int DATA_WIDTH = 32
) (
  input  logic                                   clock,
  input  logic                                   reset_n,
  input  logic                                   flush,
  output logic                                   init_done,
  input  logic                                   req_valid,
  output logic                                   req_ready,
  input  logic [TAG_WIDTH+ADDR_WIDTH-1:0]        req_addr,
  output logic                                   rsp_valid,
  output logic                                   rsp_hit,
  output logic [DATA_WIDTH-1:0]                  rsp_data,
  output logic                                   mem_rd_valid,
  input  logic                                   mem_rd_ready,
  output logic [TAG_WIDTH+ADDR_WIDTH-1:0]        mem_rd_addr,
  input  logic                                   mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]                  mem_rsp_data,
  output logic [ADDR_WIDTH-1:0]                  ram_rdaddress,
  output logic [ADDR_WIDTH-1:0]                  ram_wraddress,
  output logic [TAG_WIDTH+DATA_WIDTH:0]          ram_data,
  output logic                                   ram_wren,
  input  logic [TAG_WIDTH+DATA_WIDTH:0]          ram_q
);

  localparam int ENTRY_WIDTH = 1 + TAG_WIDTH + DATA_WIDTH;
  localparam int REQ_WIDTH   = TAG_WIDTH + ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_INDEX = {ADDR_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH-1:0] ONE_INDEX  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_INIT      = 3'd0,
    S_IDLE      = 3'd1,
    S_LOOKUP    = 3'd2,
    S_MISS_REQ  = 3'd3,
    S_MISS_WAIT = 3'd4,
    S_RESP      = 3'd5
  } state_t;

  state_t                  state_r;
  state_t                  state_s;
  logic [ADDR_WIDTH-1:0]   sweep_r;
  logic [REQ_WIDTH-1:0]    addr_r;
  logic                    rsp_hit_r;
  logic [DATA_WIDTH-1:0]   rsp_data_r;
  logic [ADDR_WIDTH-1:0]   index_s;
  logic [TAG_WIDTH-1:0]    tag_s;
  logic                    hit_s;

  function automatic logic entry_hit(input logic [ENTRY_WIDTH-1:0] entry,
                                     input logic [TAG_WIDTH-1:0]   tag);
    return entry[ENTRY_WIDTH-1] && (entry[ENTRY_WIDTH-2 -: TAG_WIDTH] == tag);
  endfunction

  assign index_s     = addr_r[ADDR_WIDTH-1:0];
  assign tag_s       = addr_r[REQ_WIDTH-1:ADDR_WIDTH];
  assign hit_s       = entry_hit(ram_q, tag_s);
  assign init_done   = (state_r != S_INIT);
  assign mem_rd_addr = addr_r;
  assign rsp_hit     = rsp_hit_r;
  assign rsp_data    = rsp_data_r;

  // Next-state and combinational RAM / handshake outputs.
  always_comb begin
    state_s       = state_r;
    req_ready     = 1'b0;
    rsp_valid     = 1'b0;
    mem_rd_valid  = 1'b0;
    ram_rdaddress = index_s;
    ram_wraddress = index_s;
    ram_data      = {ENTRY_WIDTH{1'b0}};
    ram_wren      = 1'b0;
    case (state_r)
      S_INIT: begin
        ram_wren      = 1'b1;
        ram_wraddress = sweep_r;
        if (sweep_r == LAST_INDEX) state_s = S_IDLE;
        else                       state_s = S_INIT;
      end
      S_IDLE: begin
        if (flush) begin
          state_s = S_INIT;
        end else begin
          req_ready = 1'b1;
          if (req_valid) state_s = S_LOOKUP;
          else           state_s = S_IDLE;
        end
      end
      S_LOOKUP: begin
        if (hit_s) state_s = S_RESP;
        else       state_s = S_MISS_REQ;
      end
      S_MISS_REQ: begin
        mem_rd_valid = 1'b1;
        if (mem_rd_ready) state_s = S_MISS_WAIT;
        else              state_s = S_MISS_REQ;
      end
      S_MISS_WAIT: begin
        // The fill commits on the same edge that leaves this state, so a
        // following lookup of this index sees the new entry directly.
        if (mem_rsp_valid) begin
          ram_wren = 1'b1;
          ram_data = {1'b1, tag_s, mem_rsp_data};
          state_s  = S_RESP;
        end else begin
          state_s  = S_MISS_WAIT;
        end
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        state_s   = S_IDLE;
      end
      default: state_s = S_INIT;
    endcase
  end

  // State register, sweep counter, request address and response registers.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_r    <= S_INIT;
      sweep_r    <= {ADDR_WIDTH{1'b0}};
      addr_r     <= {REQ_WIDTH{1'b0}};
      rsp_hit_r  <= 1'b0;
      rsp_data_r <= {DATA_WIDTH{1'b0}};
    end else begin
      state_r <= state_s;
      case (state_r)
        S_INIT: sweep_r <= sweep_r + ONE_INDEX;
        S_IDLE: begin
          if (flush) begin
            sweep_r <= {ADDR_WIDTH{1'b0}};
          end else if (req_valid) begin
            addr_r <= req_addr;
          end else begin
            addr_r <= addr_r;
          end
        end
        S_LOOKUP: begin
          if (hit_s) begin
            rsp_data_r <= ram_q[DATA_WIDTH-1:0];
            rsp_hit_r  <= 1'b1;
          end else begin
            rsp_hit_r  <= rsp_hit_r;
          end
        end
        S_MISS_WAIT: begin
          if (mem_rsp_valid) begin
            rsp_data_r <= mem_rsp_data;
            rsp_hit_r  <= 1'b0;
          end else begin
            rsp_hit_r  <= rsp_hit_r;
          end
        end
        default: sweep_r <= sweep_r;
      endcase
    end
  end

endmodule
